// File: rtl/nco_phase_gen.sv
// Multi-channel NCO phase generator: per-channel accumulator, offset and
// double-buffered frequency word, quadrant fold and Q15 gain; optional NCO_DITHER_EN.
module nco_phase_gen #(
    parameter int ACC_W = 32,
    parameter int PH_W  = 17,
    parameter int CH    = 2,
    parameter int SCALE = 22872
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic [$clog2(CH)-1:0] wr_addr,
    input  logic                  freq_we,
    input  logic [ACC_W-1:0]      freq_in,
    input  logic                  off_we,
    input  logic [ACC_W-1:0]      off_in,
    input  logic                  commit,
    output logic [CH*PH_W-1:0]    ph_out,
    output logic [2*CH-1:0]       quad_out,
    output logic [CH-1:0]         wrap_out,
    output logic                  valid_out
);
    localparam int AW     = $clog2(CH);
    localparam int L      = PH_W - 2;
    localparam int FRAC_W = ACC_W - PH_W;
    localparam logic [14:0] SCALE_Q15 = 15'(SCALE);

    logic [ACC_W-1:0] dither_word;

`ifdef NCO_DITHER_EN
    localparam int DW = (FRAC_W < 16) ? FRAC_W : 16;

    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards the LSB
    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
        end
    end

    // Top DW bits land just below the phase index LSB
    assign dither_word = ACC_W'(lfsr_reg[15 -: DW]) << (FRAC_W - DW);
`else
    assign dither_word = '0;
`endif

    // Valid tracks en through the three register stages and flushes with them
    logic [2:0] valid_pipe_reg;

    always_ff @(posedge clk) begin
        if (!rst || sync_clr) begin
            valid_pipe_reg <= '0;
        end else begin
            valid_pipe_reg <= {valid_pipe_reg[1:0], en};
        end
    end

    assign valid_out = valid_pipe_reg[2];

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            localparam logic [AW-1:0] CH_IDX = AW'(gi);

            logic [ACC_W-1:0] shadow_reg;
            logic [ACC_W-1:0] freq_reg;
            logic [ACC_W-1:0] off_reg;
            logic [ACC_W-1:0] acc_reg;
            logic             wrap_reg;
            logic             sel;
            logic [ACC_W:0]   acc_sum;
            logic [ACC_W-1:0] phase_sum;
            logic [PH_W-1:0]  ph_idx;
            logic [L-1:0]     alpha;
            logic [L-1:0]     alpha_reg;
            logic [1:0]       quad_b_reg;
            logic [L+14:0]    prod;
            logic [PH_W-1:0]  ph_reg;
            logic [1:0]       quad_c_reg;
            logic             unused_bits;

            assign sel = (wr_addr == CH_IDX);

            // Control registers: shadow, active frequency (write-through on commit), offset
            always_ff @(posedge clk) begin
                if (!rst) begin
                    shadow_reg <= '0;
                    freq_reg   <= '0;
                    off_reg    <= '0;
                end else begin
                    if (freq_we && sel) begin
                        shadow_reg <= freq_in;
                    end
                    if (commit) begin
                        freq_reg <= (freq_we && sel) ? freq_in : shadow_reg;
                    end
                    if (off_we && sel) begin
                        off_reg <= off_in;
                    end
                end
            end

            // Stage A: accumulate with carry capture
            assign acc_sum = {1'b0, acc_reg} + {1'b0, freq_reg};

            always_ff @(posedge clk) begin
                if (!rst || sync_clr) begin
                    acc_reg  <= '0;
                    wrap_reg <= 1'b0;
                end else if (en) begin
                    acc_reg  <= acc_sum[ACC_W-1:0];
                    wrap_reg <= acc_sum[ACC_W];
                end else begin
                    wrap_reg <= 1'b0;
                end
            end

            // Stage B: offset, truncate, fold odd quadrants back onto the rising slope
            assign phase_sum = acc_reg + off_reg + dither_word;
            assign ph_idx    = phase_sum[ACC_W-1 -: PH_W];
            assign alpha     = ph_idx[PH_W-2] ? ~ph_idx[L-1:0] : ph_idx[L-1:0];

            always_ff @(posedge clk) begin
                if (!rst || sync_clr) begin
                    alpha_reg  <= '0;
                    quad_b_reg <= '0;
                end else begin
                    alpha_reg  <= alpha;
                    quad_b_reg <= ph_idx[PH_W-1 -: 2];
                end
            end

            // Stage C: Q15 gain; SCALE < 1.0 so the result always fits in L bits
            assign prod = {15'd0, alpha_reg} * {{L{1'b0}}, SCALE_Q15};

            always_ff @(posedge clk) begin
                if (!rst || sync_clr) begin
                    ph_reg     <= '0;
                    quad_c_reg <= '0;
                end else begin
                    ph_reg     <= {2'b00, prod[L+14:15]};
                    quad_c_reg <= quad_b_reg;
                end
            end

            assign unused_bits = ^{phase_sum[FRAC_W-1:0], prod[14:0]};

            assign ph_out[gi*PH_W +: PH_W] = ph_reg;
            assign quad_out[2*gi +: 2]     = quad_c_reg;
            assign wrap_out[gi]            = wrap_reg;
        end
    endgenerate

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed self-checking bench for nco_phase_gen (default build, no dither).
module tb_nco_phase_gen;
    localparam int ACC_W = 32;
    localparam int PH_W  = 17;
    localparam int CH    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 sync_clr;
    logic [0:0]           wr_addr;
    logic                 freq_we;
    logic [ACC_W-1:0]     freq_in;
    logic                 off_we;
    logic [ACC_W-1:0]     off_in;
    logic                 commit;
    logic [CH*PH_W-1:0]   ph_out;
    logic [2*CH-1:0]      quad_out;
    logic [CH-1:0]        wrap_out;
    logic                 valid_out;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nco_phase_gen #(.ACC_W(ACC_W), .PH_W(PH_W), .CH(CH), .SCALE(22872)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .wr_addr(wr_addr),
        .freq_we(freq_we), .freq_in(freq_in), .off_we(off_we), .off_in(off_in),
        .commit(commit), .ph_out(ph_out), .quad_out(quad_out),
        .wrap_out(wrap_out), .valid_out(valid_out)
    );

    function automatic logic [PH_W-1:0] ph_ch(input int c);
        return ph_out[c*PH_W +: PH_W];
    endfunction

    function automatic logic [1:0] quad_ch(input int c);
        return quad_out[2*c +: 2];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; wr_addr = 1'b0; freq_we = 1'b1; freq_in = 32'h0800_0000;
        commit = 1'b1; off_we = 1'b1; off_in = 32'h4000_0000; sync_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({ph_out, quad_out, wrap_out, valid_out} !== '0)
                $display("FAIL reset_outputs cyc%0d: got ph=%h quad=%h wrap=%h valid=%b expected all 0",
                         i, ph_out, quad_out, wrap_out, valid_out);
            else n_pass++;
        end
        freq_we = 1'b0; commit = 1'b0; off_we = 1'b0; rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (valid_out !== (i == 3))
                $display("FAIL reset_valid_rise clk%0d: got %b expected %b", i, valid_out, (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (ph_out !== '0)
            $display("FAIL reset_freq_zero: got ph=%h expected 0", ph_out);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_quad_walk();
        logic [1:0] exp_q;
        en = 1'b0; sync_clr = 1'b1; commit = 1'b1; freq_we = 1'b1; wr_addr = 1'b0;
        freq_in = 32'h0800_0000;
        step();
        sync_clr = 1'b0; commit = 1'b0; freq_we = 1'b0; en = 1'b1;
        step();
        for (int k = 0; k < 34; k++) begin
            step();
            exp_q = 2'((k / 8) % 4);
            n_checks++;
            if (quad_ch(0) !== exp_q)
                $display("FAIL quad_walk_q k=%0d: got %0d expected %0d", k, quad_ch(0), exp_q);
            else n_pass++;
            n_checks++;
            if (valid_out !== (k >= 1))
                $display("FAIL quad_walk_valid k=%0d: got %b expected %b", k, valid_out, (k >= 1));
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if (ph_ch(0) !== 17'd2859)
                    $display("FAIL quad_walk_ph_A08 : got %0d expected 2859", ph_ch(0));
                else n_pass++;
            end
            if (k == 8) begin
                n_checks++;
                if (ph_ch(0) !== 17'd22871)
                    $display("FAIL quad_walk_ph_A40 : got %0d expected 22871", ph_ch(0));
                else n_pass++;
            end
            if (k == 9) begin
                n_checks++;
                if (ph_ch(0) !== 17'd20012)
                    $display("FAIL quad_walk_ph_A48 : got %0d expected 20012", ph_ch(0));
                else n_pass++;
            end
        end
        n_checks++;
        if (ph_ch(1) !== 17'd0 || quad_ch(1) !== 2'd0)
            $display("FAIL quad_walk_ch1_idle: got ph=%0d q=%0d expected 0/0", ph_ch(1), quad_ch(1));
        else n_pass++;
        $display("test_quad_walk done");
    endtask

    task automatic test_shadow_commit();
        logic [PH_W-1:0] exp_ph [4] = '{17'd0, 17'd0, 17'd5718, 17'd11436};
        en = 1'b0; sync_clr = 1'b1; commit = 1'b1;
        step();
        sync_clr = 1'b0; commit = 1'b0; en = 1'b1;
        freq_we = 1'b1; wr_addr = 1'b1; freq_in = 32'h1000_0000;
        step();
        freq_we = 1'b0;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (ph_ch(1) !== exp_ph[i])
                $display("FAIL shadow_commit_ph i=%0d: got %0d expected %0d", i, ph_ch(1), exp_ph[i]);
            else n_pass++;
        end
        sync_clr = 1'b1; commit = 1'b1; freq_we = 1'b1; wr_addr = 1'b1; freq_in = 32'h2000_0000;
        step();
        sync_clr = 1'b0; commit = 1'b0; freq_we = 1'b0;
        step();
        step();
        n_checks++;
        if (ph_ch(1) !== 17'd0)
            $display("FAIL write_through_restart: got %0d expected 0", ph_ch(1));
        else n_pass++;
        step();
        n_checks++;
        if (ph_ch(1) !== 17'd11436 || quad_ch(1) !== 2'd0)
            $display("FAIL write_through_step1: got ph=%0d q=%0d expected 11436/0", ph_ch(1), quad_ch(1));
        else n_pass++;
        step();
        n_checks++;
        if (ph_ch(1) !== 17'd22871 || quad_ch(1) !== 2'd1)
            $display("FAIL write_through_step2: got ph=%0d q=%0d expected 22871/1", ph_ch(1), quad_ch(1));
        else n_pass++;
        $display("test_shadow_commit done");
    endtask

    task automatic test_sync_clr_offset();
        logic [1:0] exp_q0;
        logic [1:0] exp_q1;
        en = 1'b1;
        freq_we = 1'b1; wr_addr = 1'b1; freq_in = 32'h0800_0000;
        step();
        freq_we = 1'b0;
        off_we = 1'b1; off_in = 32'h4000_0000; sync_clr = 1'b1; commit = 1'b1;
        step();
        off_we = 1'b0; sync_clr = 1'b0; commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (valid_out !== 1'b0)
                $display("FAIL sync_clr_valid_drop i=%0d: got %b expected 0", i, valid_out);
            else n_pass++;
            if (i < 2) step();
        end
        n_checks++;
        if (ph_ch(0) !== 17'd0 || quad_ch(0) !== 2'd0 || ph_ch(1) !== 17'd22871 || quad_ch(1) !== 2'd1)
            $display("FAIL sync_clr_phase_eq_offset: got ph0=%0d q0=%0d ph1=%0d q1=%0d expected 0/0/22871/1",
                     ph_ch(0), quad_ch(0), ph_ch(1), quad_ch(1));
        else n_pass++;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_q0 = 2'((k / 8) % 4);
            exp_q1 = 2'((k / 8 + 1) % 4);
            n_checks++;
            if (quad_ch(0) !== exp_q0 || quad_ch(1) !== exp_q1 || valid_out !== 1'b1)
                $display("FAIL offset_quad k=%0d: got q0=%0d q1=%0d v=%b expected %0d/%0d/1",
                         k, quad_ch(0), quad_ch(1), valid_out, exp_q0, exp_q1);
            else n_pass++;
        end
        $display("test_sync_clr_offset done");
    endtask

    task automatic test_offset_timing();
        en = 1'b0; sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step();
        step();
        off_we = 1'b1; wr_addr = 1'b0; off_in = 32'h2000_0000;
        step();
        off_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ph_ch(0) !== ((i == 2) ? 17'd11436 : 17'd0) || valid_out !== 1'b0)
                $display("FAIL offset_timing i=%0d: got ph0=%0d v=%b expected %0d/0",
                         i, ph_ch(0), valid_out, (i == 2) ? 11436 : 0);
            else n_pass++;
            if (i < 2) step();
        end
        n_checks++;
        if (ph_ch(1) !== 17'd22871 || quad_ch(1) !== 2'd1)
            $display("FAIL offset_hold_ch1: got ph1=%0d q1=%0d expected 22871/1", ph_ch(1), quad_ch(1));
        else n_pass++;
        $display("test_offset_timing done");
    endtask

    task automatic test_wrap();
        en = 1'b0; sync_clr = 1'b1; commit = 1'b1; freq_we = 1'b1; wr_addr = 1'b0;
        freq_in = 32'h8000_0000;
        step();
        sync_clr = 1'b0; commit = 1'b0; freq_we = 1'b0; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if (wrap_out !== {1'b0, (k % 2 == 0)})
                $display("FAIL wrap_pulse k=%0d: got %b expected %b", k, wrap_out, {1'b0, (k % 2 == 0)});
            else n_pass++;
        end
        en = 1'b0;
        for (int k = 9; k <= 12; k++) begin
            step();
            n_checks++;
            if (wrap_out !== 2'b00)
                $display("FAIL wrap_en_low k=%0d: got %b expected 00", k, wrap_out);
            else n_pass++;
            if (k >= 11) begin
                n_checks++;
                if (ph_ch(0) !== 17'd11436 || quad_ch(0) !== 2'd0 || valid_out !== 1'b0)
                    $display("FAIL acc_hold k=%0d: got ph0=%0d q0=%0d v=%b expected 11436/0/0",
                             k, ph_ch(0), quad_ch(0), valid_out);
                else n_pass++;
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if ({ph_out, quad_out, wrap_out, valid_out} !== '0)
            $display("FAIL reset_mid: got ph=%h quad=%h wrap=%h valid=%b expected all 0",
                     ph_out, quad_out, wrap_out, valid_out);
        else n_pass++;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (ph_out !== '0 || quad_out !== '0 || wrap_out !== '0)
                $display("FAIL reset_mid_cleared i=%0d: got ph=%h quad=%h wrap=%h expected 0",
                         i, ph_out, quad_out, wrap_out);
            else n_pass++;
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; sync_clr = 1'b0; wr_addr = 1'b0; freq_we = 1'b0;
        freq_in = '0; off_we = 1'b0; off_in = '0; commit = 1'b0;
        test_reset();
        test_quad_walk();
        test_shadow_commit();
        test_sync_clr_offset();
        test_offset_timing();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
